// File: rtl/if_else_sel_pipe_if.sv
// Handshake and data bundle between the branch generators, the select pipe
// and the downstream segment consumer.
interface if_else_sel_pipe_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [31:0]               input_bit;
   logic [1:0]                cond_mode;
   logic [4:0]                cond_sel;
   logic [31:0]               cond_thresh;
   logic [CHANNELS*WIDTH-1:0] if_data;
   logic [CHANNELS*WIDTH-1:0] else_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS*WIDTH-1:0] combine_data;
   logic [CHANNELS-1:0]       out_cond;
   logic                      clear_cnt;
   logic [CNT_W-1:0]          if_count;
   logic [CNT_W-1:0]          else_count;

   modport master (
      output in_valid, input_bit, cond_mode, cond_sel, cond_thresh,
             if_data, else_data, out_ready, clear_cnt,
      input  in_ready, out_valid, combine_data, out_cond, if_count, else_count
   );

   modport slave (
      input  in_valid, input_bit, cond_mode, cond_sel, cond_thresh,
             if_data, else_data, out_ready, clear_cnt,
      output in_ready, out_valid, combine_data, out_cond, if_count, else_count
   );
endinterface

// File: rtl/if_else_sel_pipe.sv
// Per-channel if/else select with four condition modes, an elastic pipeline
// of PIPE stages and saturating counters of branch selections.
module if_else_sel_pipe #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int PIPE     = 2,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               reset,
   if_else_sel_pipe_if.slave bus
);
   localparam int DW    = CHANNELS * WIDTH;
   localparam int PC_W  = $clog2(CHANNELS + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CHANNELS-1:0] f_cond(
      input logic [31:0] bits,
      input logic [1:0]  mode,
      input logic [4:0]  sel,
      input logic [31:0] thr
   );
      logic [CHANNELS-1:0] res;
      logic [4:0]          idx;
      res = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         // 5-bit add wraps the bit index past 31 back to 0
         idx = sel + 5'(c);
         case (mode)
            2'b00:   res[c] = bits[idx];
            2'b01:   res[c] = |bits;
            2'b10:   res[c] = (bits >= thr);
            default: res[c] = ~bits[idx];
         endcase
      end
      return res;
   endfunction

   function automatic logic [PC_W-1:0] f_popcount(input logic [CHANNELS-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int c = 0; c < CHANNELS; c++) n = n + PC_W'(v[c]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] f_sat_add(
      input logic [CNT_W-1:0] a,
      input logic [PC_W-1:0]  b
   );
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   logic [CHANNELS-1:0] w_cond;
   logic [DW-1:0]       w_sel_data;
   logic                w_acc;
   logic                w_xfer;
   logic [PC_W-1:0]     w_pop;
   logic [PIPE-1:0]     w_ld;
   logic [PIPE-1:0]     w_src_vld;
   logic [DW-1:0]       w_src_data [PIPE];
   logic [CHANNELS-1:0] w_src_cond [PIPE];

   logic [PIPE-1:0]     r_vld_p;
   logic [DW-1:0]       r_data_p [PIPE];
   logic [CHANNELS-1:0] r_cond_p [PIPE];
   logic [CNT_W-1:0]    r_if_cnt;
   logic [CNT_W-1:0]    r_else_cnt;

   always_comb begin
      w_cond     = f_cond(bus.input_bit, bus.cond_mode, bus.cond_sel, bus.cond_thresh);
      w_sel_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_sel_data[c*WIDTH +: WIDTH] = w_cond[c] ? bus.if_data[c*WIDTH +: WIDTH]
                                                  : bus.else_data[c*WIDTH +: WIDTH];
      end
   end

   // A stage may load if any stage at or after it is empty, or the output drains
   always_comb begin
      logic v_run;
      v_run = bus.out_ready;
      w_ld  = '0;
      for (int i = PIPE - 1; i >= 0; i--) begin
         v_run   = v_run || !r_vld_p[i];
         w_ld[i] = v_run;
      end
   end

   assign bus.in_ready = w_ld[0] && !reset;
   assign w_acc        = bus.in_valid && bus.in_ready;

   always_comb begin
      w_src_vld[0]  = w_acc;
      w_src_data[0] = w_sel_data;
      w_src_cond[0] = w_cond;
      for (int i = 1; i < PIPE; i++) begin
         w_src_vld[i]  = r_vld_p[i-1];
         w_src_data[i] = r_data_p[i-1];
         w_src_cond[i] = r_cond_p[i-1];
      end
   end

   // ---- pipeline stages p0 .. p(PIPE-1) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p <= '0;
         for (int i = 0; i < PIPE; i++) begin
            r_data_p[i] <= '0;
            r_cond_p[i] <= '0;
         end
      end else begin
         for (int i = 0; i < PIPE; i++) begin
            if (w_ld[i]) begin
               r_vld_p[i] <= w_src_vld[i];
               // Payload only moves with a real beat so a drained output holds its last word
               if (w_src_vld[i]) begin
                  r_data_p[i] <= w_src_data[i];
                  r_cond_p[i] <= w_src_cond[i];
               end
            end
         end
      end
   end

   // ---- output stage / selection counters ----
   assign w_xfer = r_vld_p[PIPE-1] && bus.out_ready;
   assign w_pop  = f_popcount(r_cond_p[PIPE-1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_cnt   <= '0;
         r_else_cnt <= '0;
      end else if (bus.clear_cnt) begin
         r_if_cnt   <= '0;
         r_else_cnt <= '0;
      end else if (w_xfer) begin
         r_if_cnt   <= f_sat_add(r_if_cnt, w_pop);
         r_else_cnt <= f_sat_add(r_else_cnt, PC_W'(CHANNELS) - w_pop);
      end
   end

   assign bus.out_valid    = r_vld_p[PIPE-1];
   assign bus.combine_data = r_data_p[PIPE-1];
   assign bus.out_cond     = r_cond_p[PIPE-1];
   assign bus.if_count     = r_if_cnt;
   assign bus.else_count   = r_else_cnt;
endmodule
